// File: rtl/bsg_sdr_link_reset_sequencer.sv
// bsg_sdr_link_reset_sequencer: ordered release of SDR link resets; define BSG_SDR_RESET_SEQ_AUTO_START_EN to self-start after reset
module bsg_sdr_link_reset_sequencer #(
  parameter int wait_width_p = 8,
  parameter int token_pulse_cycles_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [wait_width_p-1:0] wait_cycles_i,
  output logic                    uplink_reset_o,
  output logic                    downlink_reset_o,
  output logic                    downstream_reset_o,
  output logic                    token_reset_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int tok_w_lp = $clog2(token_pulse_cycles_p);
  localparam int cnt_w_lp = wait_width_p > tok_w_lp ? wait_width_p : tok_w_lp;
  typedef enum logic [2:0] {IDLE, ASSERT, TOKEN, SETTLE, UPREL, DNREL, DONE} state_e;
  state_e state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [wait_width_p-1:0] w_q, w_d;
  logic up_d, dn_d, ds_d, tok_d, busy_d, done_d;
  logic start, go, adv;
`ifdef BSG_SDR_RESET_SEQ_AUTO_START_EN
  logic first_q;
  assign start = start_i | first_q;
`else
  assign start = start_i;
`endif
  always_comb begin
    go = (state_q == IDLE || state_q == DONE) && start;
    adv = !(state_q == IDLE || state_q == DONE) && cnt_q == '0;
    state_d = go ? ASSERT : adv ? state_e'(state_q + 3'd1) : state_q;
    w_d = go ? wait_cycles_i : w_q;
    cnt_d = go ? cnt_w_lp'(wait_cycles_i)
          : adv ? (state_d == TOKEN ? cnt_w_lp'(token_pulse_cycles_p - 1) : cnt_w_lp'(w_q))
          : cnt_q == '0 ? cnt_q : cnt_q - cnt_w_lp'(1);
    up_d = state_d inside {IDLE, ASSERT, TOKEN, SETTLE};
    dn_d = !(state_d inside {DNREL, DONE});
    ds_d = state_d != DONE;
    tok_d = state_d == TOKEN;
    busy_d = !(state_d inside {IDLE, DONE});
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk_i) begin
`ifdef BSG_SDR_RESET_SEQ_AUTO_START_EN
    first_q <= reset_i;
`endif
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      w_q <= '0;
      {uplink_reset_o, downlink_reset_o, downstream_reset_o} <= 3'b111;
      {token_reset_o, busy_o, done_o} <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      w_q <= w_d;
      {uplink_reset_o, downlink_reset_o, downstream_reset_o} <= {up_d, dn_d, ds_d};
      {token_reset_o, busy_o, done_o} <= {tok_d, busy_d, done_d};
    end
  end
endmodule

// File: tb/tb_bsg_sdr_link_reset_sequencer.sv
// tb_bsg_sdr_link_reset_sequencer: directed checks of sequencing, timing, restart, abort and ordering
module tb_bsg_sdr_link_reset_sequencer;
  localparam logic [5:0] S_IDLE = 6'b111000, S_ASSERT = 6'b111010, S_TOKEN = 6'b111110,
                         S_SETTLE = 6'b111010, S_UPREL = 6'b011010, S_DNREL = 6'b001010,
                         S_DONE = 6'b000001;
  logic clk = 1'b0, rst = 1'b1, s0 = 1'b0, s1 = 1'b0;
  logic [7:0] w0 = '0, w1 = '0;
  logic up0, dn0, ds0, tk0, bz0, dn_o0, up1, dn1, ds1, tk1, bz1, dn_o1;
  logic [5:0] o0, o1;
  int errs = 0, checks = 0;
  assign o0 = {up0, dn0, ds0, tk0, bz0, dn_o0};
  assign o1 = {up1, dn1, ds1, tk1, bz1, dn_o1};
  always #5 clk = ~clk;
  bsg_sdr_link_reset_sequencer #(.wait_width_p(8), .token_pulse_cycles_p(4)) u0 (
    .clk_i(clk), .reset_i(rst), .start_i(s0), .wait_cycles_i(w0),
    .uplink_reset_o(up0), .downlink_reset_o(dn0), .downstream_reset_o(ds0),
    .token_reset_o(tk0), .busy_o(bz0), .done_o(dn_o0));
  bsg_sdr_link_reset_sequencer #(.wait_width_p(8), .token_pulse_cycles_p(1)) u1 (
    .clk_i(clk), .reset_i(rst), .start_i(s1), .wait_cycles_i(w1),
    .uplink_reset_o(up1), .downlink_reset_o(dn1), .downstream_reset_o(ds1),
    .token_reset_o(tk1), .busy_o(bz1), .done_o(dn_o1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] exp_at(input int k, input int w, input int p);
    return k <= w + 1 ? S_ASSERT : k <= w + 1 + p ? S_TOKEN : k <= 2 * (w + 1) + p ? S_SETTLE
         : k <= 3 * (w + 1) + p ? S_UPREL : k <= 4 * (w + 1) + p ? S_DNREL : S_DONE;
  endfunction
  always @(negedge clk) begin
    checks++;
    assert ((!tk0 || (up0 && dn0 && ds0)) && (dn0 || !up0) && (ds0 || !dn0)) else begin
      errs++;
      $error("FAIL inv_u0 got=%b", o0);
    end
    checks++;
    assert ((!tk1 || (up1 && dn1 && ds1)) && (dn1 || !up1) && (ds1 || !dn1)) else begin
      errs++;
      $error("FAIL inv_u1 got=%b", o1);
    end
  end
  initial begin
    tick();
    tick();
    chk("rst_u0", o0, S_IDLE);
    chk("rst_u1", o1, S_IDLE);
`ifdef BSG_SDR_RESET_SEQ_AUTO_START_EN
    w0 = 8'd2;
    w1 = 8'd2;
    rst = 1'b0;
    tick();
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("auto%0d", k), o0, exp_at(k, 2, 4));
      tick();
    end
`else
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("idle%0d", k), o0, S_IDLE);
    end
`endif
    w0 = 8'd3;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      chk($sformatf("nom%0d", k), o0, exp_at(k, 3, 4));
      tick();
    end
    chk("nom_hold", o0, S_DONE);
    w1 = 8'd0;
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("min%0d", k), o1, exp_at(k, 0, 1));
      tick();
    end
    w0 = 8'd3;
    s0 = 1'b1;
    tick();
    w0 = 8'd9;
    for (int k = 1; k <= 21; k++) begin
      chk($sformatf("busy%0d", k), o0, exp_at(k, 3, 4));
      tick();
    end
    s0 = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      chk($sformatf("rerun%0d", k), o0, exp_at(k, 9, 4));
      tick();
    end
    w0 = 8'd3;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    repeat (5) tick();
    chk("mid_token", o0, S_TOKEN);
    rst = 1'b1;
    tick();
    chk("abort", o0, S_IDLE);
    rst = 1'b0;
`ifndef BSG_SDR_RESET_SEQ_AUTO_START_EN
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("abort_idle%0d", k), o0, S_IDLE);
    end
`endif
    rst = 1'b1;
    s0 = 1'b1;
    tick();
    chk("rst_vs_start", o0, S_IDLE);
    rst = 1'b0;
    s0 = 1'b0;
`ifdef BSG_SDR_RESET_SEQ_AUTO_START_EN
    repeat (40) tick();
`endif
    tick();
    w0 = 8'd255;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    for (int k = 1; k <= 1029; k++) begin
      chk($sformatf("max%0d", k), o0, exp_at(k, 255, 4));
      tick();
    end
    chk("max_hold", o0, S_DONE);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
